// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO sizing constants and Gray/binary pointer conversions.
package fifo_pkg;
  localparam int ADDR_SIZE_DEF = 4;
  localparam int DEPTH = 2 ** ADDR_SIZE_DEF;
  localparam int PTR_MAXW = 13;
  function automatic logic [PTR_MAXW-1:0] bin_to_gray(input logic [PTR_MAXW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_MAXW-1:0] gray_to_bin(input logic [PTR_MAXW-1:0] g);
    logic [PTR_MAXW-1:0] b;
    b[PTR_MAXW-1] = g[PTR_MAXW-1];
    for (int i = PTR_MAXW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray2bin.sv
// gray2bin: combinational Gray-to-binary converter of parametrised width.
module gray2bin
  import fifo_pkg::*;
#(
  parameter int W = ADDR_SIZE_DEF + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);
  assign bin = W'(gray_to_bin(PTR_MAXW'(gray)));
endmodule

// File: rtl/wr_ptr_ctrl.sv
// wr_ptr_ctrl: FIFO write-side pointer, full/almost-full/level and sticky overflow tracking.
module wr_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF
) (
  input  logic                 wclk,
  input  logic                 wrst,
  input  logic                 winc,
  input  logic [ADDR_SIZE:0]   wq2_rptr,
  input  logic [ADDR_SIZE:0]   afull_thresh,
  input  logic                 wovf_clr,
  output logic                 wen,
  output logic [ADDR_SIZE-1:0] waddr,
  output logic [ADDR_SIZE:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic                 woverflow,
  output logic [ADDR_SIZE:0]   wlevel
);
  localparam int W = ADDR_SIZE + 1;
  logic [W-1:0] wbin_q, wbin_d, wptr_q, wptr_d, wlevel_q, wlevel_d, rbin;
  logic wfull_q, wfull_d, wafull_q, wafull_d, wovf_q, wovf_d;
  gray2bin #(.W(W)) u_rptr_g2b (.gray(wq2_rptr), .bin(rbin));
  assign wen = winc & ~wfull_q;
  always_comb begin
    wbin_d   = wbin_q + {{ADDR_SIZE{1'b0}}, wen};
    wptr_d   = W'(bin_to_gray(PTR_MAXW'(wbin_d)));
    // full when the write pointer is one lap ahead: Gray form flips the top two bits
    wfull_d  = wptr_d == {~wq2_rptr[W-1:W-2], wq2_rptr[W-3:0]};
    wlevel_d = wbin_d - rbin;
    wafull_d = wlevel_d >= afull_thresh;
    wovf_d   = (winc & wfull_q) | (wovf_q & ~wovf_clr);
  end
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wbin_q   <= '0;
      wptr_q   <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wptr_q   <= wptr_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end
  assign waddr        = wbin_q[ADDR_SIZE-1:0];
  assign wptr         = wptr_q;
  assign wlevel       = wlevel_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign woverflow    = wovf_q;
endmodule

// File: tb/tb_wr_ptr_ctrl.sv
// tb_wr_ptr_ctrl: randomized self-checking bench with a write/read count reference model.
module tb_wr_ptr_ctrl;
  logic       wclk = 1'b0, wrst = 1'b0, winc = 1'b0, wovf_clr = 1'b0;
  logic [4:0] wq2_rptr = '0, afull_thresh = '0;
  logic       wen, wfull, walmost_full, woverflow;
  logic [3:0] waddr;
  logic [4:0] wptr, wlevel;
  int n_cmp = 0, n_err = 0;
  int wc = 0, rc = 0, thresh = 31;
  bit m_full = 0, m_ovf = 0, m_af = 0;

  wr_ptr_ctrl #(.ADDR_SIZE(4)) dut (
    .wclk(wclk), .wrst(wrst), .winc(winc), .wq2_rptr(wq2_rptr),
    .afull_thresh(afull_thresh), .wovf_clr(wovf_clr), .wen(wen), .waddr(waddr),
    .wptr(wptr), .wfull(wfull), .walmost_full(walmost_full),
    .woverflow(woverflow), .wlevel(wlevel)
  );

  always #5 wclk = ~wclk;

  function automatic logic [4:0] gray5(input int n);
    int b;
    b = n % 32;
    return 5'(b ^ (b >> 1));
  endfunction

  task automatic cyc(input logic w, input logic c);
    bit was_full;
    winc = w;
    wovf_clr = c;
    wq2_rptr = gray5(rc);
    afull_thresh = 5'(thresh);
    @(posedge wclk);
    #1;
    was_full = m_full;
    if (wrst) begin
      wc = 0; m_full = 0; m_ovf = 0; m_af = 0;
    end else begin
      if (w && !was_full) wc++;
      m_full = (wc - rc) == 16;
      m_af   = (wc - rc) >= thresh;
      m_ovf  = (w && was_full) || (m_ovf && !c);
    end
  endtask

  task automatic do_reset();
    rc = 0;
    wrst = 1'b1;
    cyc(1'b0, 1'b0);
    wrst = 1'b0;
  endtask

  task automatic test_reset();
    wrst = 1'b1;
    rc = 0;
    winc = 1'b1;
    #1;
    n_cmp++; if (wen !== 1'b1) begin n_err++; $display("FAIL rst_wen got=%b exp=1", wen); end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    wrst = 1'b0;
    n_cmp++; if (wptr !== 5'd0) begin n_err++; $display("FAIL rst_wptr got=%h exp=0", wptr); end
    n_cmp++; if (waddr !== 4'd0) begin n_err++; $display("FAIL rst_waddr got=%h exp=0", waddr); end
    n_cmp++; if (wlevel !== 5'd0) begin n_err++; $display("FAIL rst_wlevel got=%0d exp=0", wlevel); end
    n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL rst_wfull got=%b exp=0", wfull); end
    n_cmp++; if (woverflow !== 1'b0) begin n_err++; $display("FAIL rst_wovf got=%b exp=0", woverflow); end
    n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL rst_wafull got=%b exp=0", walmost_full); end
  endtask

  task automatic test_fill();
    thresh = 31;
    do_reset();
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b0);
    n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL fill15_wfull got=%b exp=0", wfull); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (wfull !== 1'b1) begin n_err++; $display("FAIL fill_wfull got=%b exp=1", wfull); end
    n_cmp++; if (wptr !== 5'b11000) begin n_err++; $display("FAIL fill_wptr got=%b exp=11000", wptr); end
    n_cmp++; if (wlevel !== 5'd16) begin n_err++; $display("FAIL fill_wlevel got=%0d exp=16", wlevel); end
    n_cmp++; if (waddr !== 4'd0) begin n_err++; $display("FAIL fill_waddr got=%0d exp=0", waddr); end
  endtask

  task automatic test_overflow();
    winc = 1'b1;
    #1;
    n_cmp++; if (wen !== 1'b0) begin n_err++; $display("FAIL ovf_wen got=%b exp=0", wen); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (wptr !== 5'b11000) begin n_err++; $display("FAIL ovf_wptr got=%b exp=11000", wptr); end
    n_cmp++; if (wlevel !== 5'd16) begin n_err++; $display("FAIL ovf_wlevel got=%0d exp=16", wlevel); end
    n_cmp++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set got=%b exp=1", woverflow); end
    cyc(1'b0, 1'b0);
    n_cmp++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_hold got=%b exp=1", woverflow); end
    cyc(1'b0, 1'b1);
    n_cmp++; if (woverflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", woverflow); end
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    n_cmp++; if (woverflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got=%b exp=1", woverflow); end
    cyc(1'b0, 1'b1);
    n_cmp++; if (woverflow !== m_ovf) begin n_err++; $display("FAIL ovf_final got=%b exp=%b", woverflow, m_ovf); end
  endtask

  task automatic test_release();
    rc = rc + 1;
    cyc(1'b0, 1'b0);
    n_cmp++; if (wfull !== 1'b0) begin n_err++; $display("FAIL release_wfull got=%b exp=0", wfull); end
    n_cmp++; if (wlevel !== 5'd15) begin n_err++; $display("FAIL release_wlevel got=%0d exp=15", wlevel); end
  endtask

  task automatic test_almost_full();
    thresh = 12;
    do_reset();
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b0);
    n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL af11 got=%b exp=0", walmost_full); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (walmost_full !== 1'b1) begin n_err++; $display("FAIL af12 got=%b exp=1", walmost_full); end
    rc = 2;
    cyc(1'b0, 1'b0);
    n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL af_read got=%b exp=0", walmost_full); end
    n_cmp++; if (wlevel !== 5'd10) begin n_err++; $display("FAIL af_wlevel got=%0d exp=10", wlevel); end
    thresh = 0;
    do_reset();
    cyc(1'b0, 1'b0);
    n_cmp++; if (walmost_full !== 1'b1) begin n_err++; $display("FAIL af_zero got=%b exp=1", walmost_full); end
    thresh = 17;
    for (int i = 0; i < 17; i++) cyc(1'b1, 1'b0);
    n_cmp++; if (walmost_full !== 1'b0) begin n_err++; $display("FAIL af_above got=%b exp=0", walmost_full); end
  endtask

  task automatic test_wrap();
    int errs = 0;
    bit wrapped = 0;
    thresh = 0;
    do_reset();
    thresh = $urandom_range(1, 16);
    for (int i = 0; i < 200; i++) begin
      if (rc < wc && $urandom_range(0, 2) == 0) rc++;
      cyc(($urandom_range(0, 3) != 0), $urandom_range(0, 1));
      if (wc >= 32) wrapped = 1;
      n_cmp++;
      if (wlevel !== 5'(wc - rc) || wfull !== m_full || (wfull && wlevel !== 5'd16) ||
          wptr !== gray5(wc) || waddr !== 4'(wc % 16) || walmost_full !== m_af || woverflow !== m_ovf) begin
        n_err++; errs++;
        if (errs < 6)
          $display("FAIL wrap_cyc%0d got lvl=%0d full=%b ptr=%b addr=%0d af=%b ovf=%b exp lvl=%0d full=%b ptr=%b addr=%0d af=%b ovf=%b",
                   i, wlevel, wfull, wptr, waddr, walmost_full, woverflow,
                   wc - rc, m_full, gray5(wc), wc % 16, m_af, m_ovf);
      end
    end
    n_cmp++; if (!wrapped) begin n_err++; $display("FAIL wrap_reached got=%0d writes exp>=32", wc); end
  endtask

  task automatic test_mid_reset();
    thresh = 0;
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0);
    wrst = 1'b1;
    cyc(1'b1, 1'b1);
    wrst = 1'b0;
    n_cmp++;
    if ({wptr, waddr, wlevel, wfull, walmost_full, woverflow} !== '0) begin
      n_err++;
      $display("FAIL midrst_outputs got ptr=%b addr=%0d lvl=%0d full=%b af=%b ovf=%b exp all 0",
               wptr, waddr, wlevel, wfull, walmost_full, woverflow);
    end
    winc = 1'b1;
    #1;
    n_cmp++; if (waddr !== 4'd0 || wen !== 1'b1) begin n_err++; $display("FAIL midrst_first got addr=%0d wen=%b exp addr=0 wen=1", waddr, wen); end
    cyc(1'b1, 1'b0);
    n_cmp++; if (wlevel !== 5'd1) begin n_err++; $display("FAIL midrst_wlevel got=%0d exp=1", wlevel); end
    n_cmp++; if (waddr !== 4'd1) begin n_err++; $display("FAIL midrst_waddr got=%0d exp=1", waddr); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_release();
    test_almost_full();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/wr_ptr_ctrl.md
WR_PTR_CTRL -- requirements
Module: wr_ptr_ctrl

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 4: FIFO depth is 2**ADDR_SIZE; legal range 2..12.
REQ-002 SHALL have port wclk, input, 1 bit: the single write-domain clock; all state updates on its rising edge.
REQ-003 SHALL have port wrst, input, 1 bit: reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port winc, input, 1 bit: write request.
REQ-005 SHALL have port wq2_rptr, input, ADDR_SIZE+1 bits: Gray read pointer, already synchronised into wclk.
REQ-006 SHALL have port afull_thresh, input, ADDR_SIZE+1 bits: almost-full level threshold.
REQ-007 SHALL have port wovf_clr, input, 1 bit: clears the sticky overflow flag.
REQ-008 SHALL have port wen, output, 1 bit: memory write enable, combinational, equal to winc & ~wfull.
REQ-009 SHALL have port waddr, output, ADDR_SIZE bits: memory write address, equal to the low bits of the registered binary pointer.
REQ-010 SHALL have port wptr, output, ADDR_SIZE+1 bits: registered Gray write pointer for the read-side synchroniser.
REQ-011 SHALL have ports wfull, walmost_full and woverflow, each output, 1 bit, each registered.
REQ-012 SHALL have port wlevel, output, ADDR_SIZE+1 bits: registered fill level, range 0..2**ADDR_SIZE.

Function
REQ-013 SHALL compute wbin_next = wbin + wen, modulo 2**(ADDR_SIZE+1), and wgray_next = (wbin_next >> 1) XOR wbin_next; both SHALL register each cycle.
REQ-014 SHALL register wfull as 1 when wgray_next equals wq2_rptr with its two MSBs inverted and its remaining bits unchanged, else 0: one cycle of latency.
REQ-015 SHALL convert wq2_rptr from Gray to binary (rbin) combinationally and register wlevel = wbin_next - rbin, modulo 2**(ADDR_SIZE+1).
REQ-016 SHALL register walmost_full = (wlevel_next >= afull_thresh), unsigned compare; afull_thresh = 0 forces it to 1 out of reset; afull_thresh greater than depth leaves it at 0.
REQ-017 SHALL set woverflow on the edge after any cycle with winc=1 and wfull=1; it SHALL hold until a cycle with wovf_clr=1 and no new overflow, and a set in the same cycle as a clear SHALL win.
REQ-018 A rejected write (winc=1 while wfull=1) SHALL leave wbin, wptr and wlevel unchanged.
REQ-019 Pointer wrap from 2**(ADDR_SIZE+1)-1 to 0 SHALL be seamless: no flag glitch, and wlevel SHALL stay correct across the wrap.
REQ-020 wfull SHALL deassert on the edge after wq2_rptr advances while no write is accepted.

Reset
REQ-021 While wrst=1 at a wclk edge, wbin, wptr, wlevel, wfull and woverflow SHALL become 0, and walmost_full SHALL become 0; reset SHALL override winc and wovf_clr.
REQ-022 Reset asserted mid-fill SHALL discard all pointer state; the first write after release SHALL target waddr 0.
REQ-023 wen SHALL follow winc while wrst=1, since wfull is 0; the integrator gates memory writes during reset.

Structure
REQ-024 The shared package fifo_pkg SHALL hold the default ADDR_SIZE, a depth constant, and the Gray/binary conversion functions.
REQ-025 The Gray-to-binary converter SHALL be a separate sub-module gray2bin, parametrised by width, instanced once for wq2_rptr.
REQ-026 The block SHALL contain no storage array; memory and synchronisers are external.

Verification (ADDR_SIZE=4)
REQ-027 Reset: wrst=1 for 2 cycles with winc=1 -> wptr=0, waddr=0, wlevel=0, wfull=0, woverflow=0.
REQ-028 Fill: wq2_rptr=0, 16 consecutive writes -> wfull=1 after the 16th edge, wptr=5'b11000, wlevel=16, waddr=0.
REQ-029 Overflow: from full, winc=1 for 1 cycle -> wen=0, wptr unchanged, woverflow=1 next edge; wovf_clr=1 -> woverflow=0; clear plus a new overflow in the same cycle -> woverflow stays 1.
REQ-030 Almost-full: afull_thresh=12 -> walmost_full=0 after 11 writes and 1 after 12 writes; advancing the read pointer by 2 (Gray) -> walmost_full=0 and wlevel=10.
REQ-031 Wrap: random winc plus a read-pointer model over 200 cycles crossing a binary wrap 31->0 -> wlevel matches the model every cycle, and wfull asserts only when wlevel=16.
REQ-032 Mid-operation reset: wrst=1 after 7 writes -> all outputs 0 next edge; the next write gives waddr=0 and wlevel=1.
